// File: rtl/mult_seq_shift_add_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: state
// encodings, counter sizing and the half-adder cell used by the ripple adder.
package mult_seq_shift_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Iteration counter has to hold 0..N-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Half-adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/mult_seq_shift_add_if.sv
// Operand/product handshake bundle for mult_seq_shift_add.
interface mult_seq_shift_add_if #(
    parameter int BITWIDTH = 8
);

    // Both channels use valid/ready: a transfer happens on a rising clock edge
    // where VLD and RDY are both high; the source holds its data stable and
    // keeps VLD high until that edge, and RDY never depends on data values.
    logic                    IN_VLD;
    logic                    IN_RDY;
    logic [BITWIDTH-1:0]     A;
    logic [BITWIDTH-1:0]     B;
    logic [2*BITWIDTH-1:0]   DOUT;
    logic                    DOUT_VLD;
    logic                    DOUT_RDY;

    modport master (
        output IN_VLD, A, B, DOUT_RDY,
        input  IN_RDY, DOUT, DOUT_VLD
    );

    modport slave (
        input  IN_VLD, A, B, DOUT_RDY,
        output IN_RDY, DOUT, DOUT_VLD
    );

endinterface

// File: rtl/mult_seq_shift_add_adder.sv
// N-bit combinational ripple-carry adder assembled from half-adder cells;
// each bit pairs two half adders and ORs their carries.
module adder_ripple_nbit
    import mult_seq_shift_add_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] A,
    input  logic [BITWIDTH-1:0] B,
    input  logic                Cin,
    output logic [BITWIDTH-1:0] Q,
    output logic                Cout
);

    logic [BITWIDTH:0] carry;

    assign carry[0] = Cin;

    // Bit 0 starts from the plain half-adder cell; its second half adder only
    // absorbs Cin, which the multiplier ties low.
    for (genvar i = 0; i < BITWIDTH; i++) begin : g_bit
        logic [1:0] ha0;
        logic [1:0] ha1;
        assign ha0          = half_add(A[i], B[i]);
        assign ha1          = half_add(ha0[0], carry[i]);
        assign Q[i]         = ha1[0];
        assign carry[i+1]   = ha0[1] | ha1[1];
    end

    assign Cout = carry[BITWIDTH];

endmodule

// File: rtl/mult_seq_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// valid/ready on operand and product sides, product after exactly N edges.
module mult_seq_shift_add
    import mult_seq_shift_add_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    mult_seq_shift_add_if.slave   bus,
    output logic                  BUSY,
    output state_t                dbg_state_o
);

    localparam int N  = BITWIDTH;
    localparam int CW = cnt_width(N);

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [2*N:0]     acc_q,   acc_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [2*N-1:0]   dout_q,  dout_d;

    logic [N-1:0]     add_q;
    logic             add_c;
    logic [N:0]       step_sum;
    logic [2*N:0]     acc_shift;
    logic             last_iter;

    adder_ripple_nbit #(
        .BITWIDTH (N)
    ) u_adder (
        .A    (acc_q[2*N-1:N]),
        .B    (mcand_q),
        .Cin  (1'b0),
        .Q    (add_q),
        .Cout (add_c)
    );

    // acc_q[2N] is always zero at the start of an iteration, so the no-add path
    // matches {0, acc[2N-1:N]}; the full N+1-bit sum is kept before shifting.
    assign step_sum  = acc_q[0] ? {add_c, add_q} : acc_q[2*N:N];
    assign acc_shift = {1'b0, step_sum, acc_q[N-1:1]};
    assign last_iter = (cnt_q == CW'(N - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.IN_VLD) state_d = CALC;
            CALC:    if (last_iter)  state_d = DONE;
            DONE:    if (bus.DOUT_RDY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (bus.IN_VLD) begin
                    mcand_d = bus.A;
                    acc_d   = {{(N+1){1'b0}}, bus.B};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) dout_d = acc_shift[2*N-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.IN_RDY   = (state_q == IDLE);
        bus.DOUT_VLD = (state_q == DONE);
        BUSY         = (state_q == CALC) || (state_q == DONE);
    end

    assign bus.DOUT    = dout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Self-checking bench for mult_seq_shift_add (N=8): directed cases, backpressure,
// ignored operands during CALC, mid-operation reset and a random soak.
module tb_mult_seq_shift_add;
  import mult_seq_shift_add_pkg::*;

  localparam int N   = 8;
  localparam int PER = 10;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_t dbg_state;

  mult_seq_shift_add_if #(.BITWIDTH(N)) bus();

  mult_seq_shift_add #(.BITWIDTH(N)) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .bus         (bus),
    .BUSY        (busy),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [2*N-1:0] exp_q[$];
  time            t_q[$];

  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;
  logic prev_vld  = 1'b0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #(PER/2) clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    bus.DOUT_RDY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.DOUT_RDY = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.DOUT_VLD && !prev_vld) begin
        if (t_q.size() == 0) check("lat_unexpected", 32'd1, 32'd0);
        else check("latency", 32'(($time - PER/2 - t_q.pop_front()) / PER), 32'(N));
      end
      if (bus.DOUT_VLD && bus.DOUT_RDY) begin
        if (exp_q.size() == 0) check("dout_unexpected", 32'(bus.DOUT), 32'hDEAD_BEEF);
        else check("dout", 32'(bus.DOUT), 32'(exp_q.pop_front()));
      end
      prev_vld = bus.DOUT_VLD;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int k = 0;
    logic [2*N-1:0] prod;
    @(negedge clk);
    while (!bus.IN_RDY && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.IN_RDY) begin
      check("send_timeout", 32'd0, 32'd1);
      return;
    end
    bus.A      = a;
    bus.B      = b;
    bus.IN_VLD = 1'b1;
    @(posedge clk);
    prod = {{N{1'b0}}, a};
    prod = prod * {{N{1'b0}}, b};
    t_q.push_back($time);
    exp_q.push_back(prod);
    #1;
    bus.IN_VLD = 1'b0;
    bus.A      = N'($urandom);
    bus.B      = N'($urandom);
  endtask

  task automatic wait_vld();
    int k = 0;
    while (!bus.DOUT_VLD && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("vld_timeout", 32'(bus.DOUT_VLD), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0]   tab_a [4] = '{8'hFF, 8'h00, 8'h80, 8'hA5};
  logic [N-1:0]   tab_b [4] = '{8'hFF, 8'hA5, 8'h02, 8'h00};
  logic [2*N-1:0] tab_p [4] = '{16'hFE01, 16'h0000, 16'h0100, 16'h0000};

  initial begin
    int k;
    bus.IN_VLD = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #1;
    check("rst_in_rdy",   32'(bus.IN_RDY),   32'd1);
    check("rst_dout",     32'(bus.DOUT),     32'd0);
    check("rst_dout_vld", 32'(bus.DOUT_VLD), 32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_state",    32'(dbg_state),    32'(IDLE));
    #20 rst_n = 1'b1;

    // basic product, 1-cycle pulse with DOUT_RDY high
    send(8'd13, 8'd11);
    check("calc_busy", 32'(busy), 32'd1);
    wait_vld();
    check("dout_13x11", 32'(bus.DOUT), 32'h008F);
    @(negedge clk);
    check("pulse_vld_low", 32'(bus.DOUT_VLD), 32'd0);
    check("in_rdy_back",   32'(bus.IN_RDY),   32'd1);
    check("dout_hold_idle", 32'(bus.DOUT),    32'h008F);

    // boundary operands
    for (int i = 0; i < 4; i++) begin
      send(tab_a[i], tab_b[i]);
      wait_vld();
      check("dout_table", 32'(bus.DOUT), 32'(tab_p[i]));
      @(negedge clk);
    end

    // backpressure: product held stable while DOUT_RDY is low
    rdy_force = 1'b0;
    send(8'd7, 8'd9);
    wait_vld();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_dout",   32'(bus.DOUT),     32'h003F);
      check("stall_vld",    32'(bus.DOUT_VLD), 32'd1);
      check("stall_in_rdy", 32'(bus.IN_RDY),   32'd0);
    end
    rdy_force = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("stall_release_vld", 32'(bus.DOUT_VLD), 32'd0);

    // operands offered during CALC are ignored
    send(8'd2, 8'd5);
    @(negedge clk);
    @(negedge clk);
    check("calc_in_rdy", 32'(bus.IN_RDY), 32'd0);
    bus.A      = 8'd3;
    bus.B      = 8'd3;
    bus.IN_VLD = 1'b1;
    @(negedge clk);
    bus.IN_VLD = 1'b0;
    wait_vld();
    check("dout_2x5", 32'(bus.DOUT), 32'h000A);
    repeat (N + 4) @(negedge clk);
    check("no_extra_busy", 32'(busy), 32'd0);
    check("no_extra_vld",  32'(bus.DOUT_VLD), 32'd0);

    // asynchronous reset two edges into CALC
    send(8'd9, 8'd9);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_rdy", 32'(bus.IN_RDY),   32'd1);
    check("midrst_dout",   32'(bus.DOUT),     32'd0);
    check("midrst_vld",    32'(bus.DOUT_VLD), 32'd0);
    check("midrst_busy",   32'(busy),         32'd0);
    check("midrst_state",  32'(dbg_state),    32'(IDLE));
    exp_q.delete();
    t_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd6, 8'd7);
    wait_vld();
    check("dout_6x7", 32'(bus.DOUT), 32'h002A);
    @(negedge clk);

    // random soak with random consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) send(N'($urandom), N'($urandom));
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    rdy_rand = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("no_pending_latency", 32'(t_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
